lsu_unit: RTL
=============

# lsu_unit

Multi-cycle load/store unit in the execute/memory path, directly downstream of the ALU. It consumes the ALU result as the effective address and `rs2` as store data. It drives a req/ack data-memory port, stalls the core until the access completes, and returns sign- or zero-extended load data for writeback. It also detects bus timeouts, illegal encodings and, optionally, misaligned accesses.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum REQ cycles without `mem_ack` before a bus error; legal range 1..65535.
- `CNT_W`, default 16: width of the timeout counter; must hold `TIMEOUT`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  memory instruction present; held high by the core until `done`.
- `op_load`  in  1  instruction is a load.
- `op_store`  in  1  instruction is a store.
- `funct3`  in  3  RISC-V width/sign code: LB=000, LH=001, LW=010, LBU=100, LHU=101; SB=000, SH=001, SW=010.
- `addr`  in  32  effective address (ALU `Result`).
- `wdata`  in  32  store data (`rs2`).
- `stall`  out  1  combinational; freezes the PC and pipeline.
- `done`  out  1  registered one-cycle completion pulse.
- `rdata`  out  32  registered, extended load data; valid when `done`=1.
- `err`  out  1  registered; valid with `done`; set for timeout or illegal op.
- `misalign`  out  1  registered; valid with `done`.
- `mem_req`  out  1  request; high only in state REQ.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word address: `{addr[31:2],2'b00}`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-steered store data.
- `mem_ack`  in  1  completion, sampled while in REQ.
- `mem_rdata`  in  32  read word; valid with `mem_ack`.

## Operation
- FSM states: IDLE, REQ, DONE.
- In IDLE with `start`=1:
  - A legal, aligned access latches address, we, be and wdata, clears the counter, then goes to REQ.
  - An illegal or misaligned access goes directly to DONE.
- Illegal access is any of:
  - `op_load` equals `op_store`.
  - A load `funct3` not in {000,001,010,100,101}.
  - A store `funct3` not in {000,001,010}.
- Illegal access gives `err`=1 in DONE and never raises `mem_req`.
- REQ:
  - `mem_req`=1; address, we, be and wdata are held stable.
  - `mem_ack`=1 → DONE; a load captures the extended `mem_rdata`.
  - Otherwise the counter increments. When the counter reaches `TIMEOUT` → DONE with `err`=1 and `rdata`=0.
  - `mem_ack` in the timeout cycle counts as success.
- DONE: `done`=1 for exactly one cycle; `start` is ignored; next state is IDLE.
- `stall` = (IDLE & `start`) | REQ. It is 0 in DONE.
- Store steering, with lane = `addr[1:0]`:
  - SB: be=`0001<<lane`, data = byte replicated ×4.
  - SH: be=`0011<<lane`, data = halfword replicated ×2.
  - SW: be=1111.
- Load extraction: select byte/halfword at the lane. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Stores return `rdata`=0.

## Timing
- Reset: state IDLE, counter 0. `done`, `err`, `misalign`, `rdata`, `mem_req`, `mem_we`, `mem_be`, `mem_addr` and `mem_wdata` are all 0.
- Reset mid-REQ: `mem_req` is 0 from the cycle after the reset edge. The pending transaction is abandoned and no `done` is issued.
- Minimum access: `start` at cycle 0 → REQ at 1. `mem_ack` at 1 → `done` at 2. `stall` is high in cycles 0–1.
- Each wait cycle of `mem_ack` adds one cycle of latency.
- Timeout: `done` and `err` arrive `TIMEOUT`+1 cycles after entering REQ.
- Illegal or misaligned access: `done` one cycle after `start`.
- `mem_ack` outside REQ is ignored.

## Configuration
- Macro `LSU_MISALIGN_TRAP_EN`.
- Defined: a misaligned access issues no request and reports `misalign`=1, `err`=0 in DONE. Misaligned means LH/LHU/SH with `addr[0]`=1, or LW/SW with `addr[1:0]`≠0.
- Undefined: the lane bits below natural alignment are forced to 0 and the access proceeds; `misalign` is tied 0.

## Structure
- Package `lsu_pkg` holds:
  - `funct3` constants.
  - FSM state typedef.
  - Base byte-enable masks (BE_B=0001, BE_H=0011, BE_W=1111).
- One sub-module, `lsu_align`: purely combinational store lane steering, byte enables and load extract/extend. It is instantiated once in `lsu_unit`.

## Test plan
- SW addr=0x100, wdata=0xDEADBEEF, ack on first REQ cycle → `mem_be`=1111, `mem_addr`=0x100, `done` at cycle 2, `stall` high for 2 cycles.
- LB addr=0x203, `mem_rdata`=0x80FF_1234, ack after 3 waits → `rdata`=0xFFFFFF80, `done` 5 cycles after `start`. LBU at the same address → 0x00000080.
- SH addr=0x302, wdata=0x0000ABCD → `mem_be`=1100, `mem_wdata`=0xABCDABCD. LHU addr=0x302 with `mem_rdata`=0x8001_0000 → `rdata`=0x00008001.
- `TIMEOUT`=4 with `mem_ack` never asserted → `done`=1, `err`=1, `rdata`=0, 5 cycles after entering REQ. A variant acking in the timeout cycle → `err`=0.
- LW addr=0x102 → with the macro: no `mem_req`, `misalign`=1, `done` at cycle 1. Without it: `mem_addr`=0x100, be=1111.
- Illegal `op_load`=`op_store`=1, and `rst_n` low during REQ → illegal: `err`=1, no `mem_req`. Reset: `mem_req`=0 the next cycle, FSM in IDLE, no `done`.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// base byte-enable masks and small decode helpers.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [3:0] BE_B = 4'b0001;
   localparam logic [3:0] BE_H = 4'b0011;
   localparam logic [3:0] BE_W = 4'b1111;

   typedef enum logic [1:0] {IDLE, REQ, DONE} lsu_state_t;

   function automatic logic is_legal(input logic ld, input logic st, input logic [2:0] f3);
      if (ld == st) return 1'b0;
      if (ld) return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
      return f3 inside {F3_B, F3_H, F3_W};
   endfunction

   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
      case (f3[1:0])
         2'b01:   return lane[0];
         2'b10:   return lane != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

   // Clears the lane bits below the natural alignment of the access width.
   function automatic logic [1:0] natural_lane(input logic [2:0] f3, input logic [1:0] lane);
      case (f3[1:0])
         2'b01:   return {lane[1], 1'b0};
         2'b10:   return 2'b00;
         default: return lane;
      endcase
   endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory req/ack port between the load/store unit (master) and memory (slave).
interface lsu_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte enables / data replication and
// load byte/halfword extraction with sign or zero extension.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] wdata_lane,
   output logic [31:0] rdata_ext
);

   logic [31:0] rshift;

   always_comb begin
      be         = BE_W;
      wdata_lane = wdata;
      case (funct3[1:0])
         2'b00: begin
            be         = BE_B << lane;
            wdata_lane = {4{wdata[7:0]}};
         end
         2'b01: begin
            be         = BE_H << lane;
            wdata_lane = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   assign rshift = rword >> {lane, 3'b000};

   always_comb begin
      rdata_ext = rword;
      case (funct3)
         F3_B:    rdata_ext = {{24{rshift[7]}}, rshift[7:0]};
         F3_H:    rdata_ext = {{16{rshift[15]}}, rshift[15:0]};
         F3_BU:   rdata_ext = {24'd0, rshift[7:0]};
         F3_HU:   rdata_ext = {16'd0, rshift[15:0]};
         default: rdata_ext = rword;
      endcase
   end

endmodule

// File: rtl/lsu_unit.sv
// Multi-cycle load/store unit: req/ack memory port, timeout and illegal-op
// detection. Define LSU_MISALIGN_TRAP_EN to trap misaligned accesses.
module lsu_unit
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        op_load,
   input  logic        op_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        done,
   output logic [31:0] rdata,
   output logic        err,
   output logic        misalign,
   lsu_if.master       mem
);

   lsu_state_t state;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       f3_q;
   logic [1:0]       lane_q;

   logic        legal;
   logic        trap_misal;
   logic [1:0]  lane_eff;
   logic [2:0]  al_f3;
   logic [1:0]  al_lane;
   logic [3:0]  be_n;
   logic [31:0] wdata_n;
   logic [31:0] rdata_n;

   assign legal = is_legal(op_load, op_store, funct3);

`ifdef LSU_MISALIGN_TRAP_EN
   assign trap_misal = is_misaligned(funct3, addr[1:0]);
   assign lane_eff   = addr[1:0];
`else
   assign trap_misal = 1'b0;
   assign lane_eff   = natural_lane(funct3, addr[1:0]);
`endif

   // Steering uses the live instruction in IDLE; extraction uses the latched one in REQ.
   assign al_f3   = (state == IDLE) ? funct3   : f3_q;
   assign al_lane = (state == IDLE) ? lane_eff : lane_q;

   lsu_align u_align (
      .funct3     (al_f3),
      .lane       (al_lane),
      .wdata      (wdata),
      .rword      (mem.mem_rdata),
      .be         (be_n),
      .wdata_lane (wdata_n),
      .rdata_ext  (rdata_n)
   );

   assign stall = ((state == IDLE) && start) || (state == REQ);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         f3_q          <= '0;
         lane_q        <= '0;
         done          <= 1'b0;
         err           <= 1'b0;
         misalign      <= 1'b0;
         rdata         <= '0;
         mem.mem_req   <= 1'b0;
         mem.mem_we    <= 1'b0;
         mem.mem_addr  <= '0;
         mem.mem_be    <= '0;
         mem.mem_wdata <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  err      <= 1'b0;
                  misalign <= 1'b0;
                  rdata    <= '0;
                  if (!legal) begin
                     state <= DONE;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else if (trap_misal) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     misalign <= 1'b1;
                  end else begin
                     state         <= REQ;
                     cnt           <= '0;
                     f3_q          <= funct3;
                     lane_q        <= lane_eff;
                     mem.mem_req   <= 1'b1;
                     mem.mem_we    <= op_store;
                     mem.mem_addr  <= {addr[31:2], 2'b00};
                     mem.mem_be    <= be_n;
                     mem.mem_wdata <= wdata_n;
                  end
               end
            end
            REQ: begin
               // An ack in the final counted cycle still wins over the timeout.
               if (mem.mem_ack) begin
                  state       <= DONE;
                  done        <= 1'b1;
                  mem.mem_req <= 1'b0;
                  if (!mem.mem_we) rdata <= rdata_n;
               end else if (cnt == CNT_W'(TIMEOUT)) begin
                  state       <= DONE;
                  done        <= 1'b1;
                  err         <= 1'b1;
                  rdata       <= '0;
                  mem.mem_req <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
